// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and counter sizing for the PLL lock supervisor
package pll_sup_pkg;
    localparam int SUP_STATE_W = 3;

    typedef enum logic [SUP_STATE_W-1:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } sup_state_e;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction
endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs, async-reset to zero
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q, sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: owns PLL reset, waits for stable lock with timeout/retry,
// then releases downstream stage resets one at a time; any lock loss restarts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLLS      = 4,
    parameter int NUM_STAGES    = 4,
    parameter int ARESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                   clk_100m_in,
    input  logic                   rst,
    input  logic [NUM_PLLS-1:0]    pll_locked,
    input  logic                   retry_req,
    output logic                   pll_areset,
    output logic [NUM_STAGES-1:0]  rst_stage_n,
    output logic                   all_ready,
    output logic                   fault,
    output logic [SUP_STATE_W-1:0] sup_state,
    output logic [7:0]             lock_loss_count
);
    localparam int AW = cnt_w(ARESET_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT);
    localparam int SW = cnt_w(STABLE_CYCLES);
    localparam int GW = cnt_w(STAGE_GAP);
    localparam int RW = cnt_w(MAX_RETRIES);

    logic [NUM_PLLS-1:0]   lk_sync;
    logic                  all_lk, lose, step;
    sup_state_e            state_q, state_d;
    logic [AW-1:0]         ar_q, ar_d;
    logic [TW-1:0]         to_q, to_d;
    logic [SW-1:0]         st_q, st_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [RW-1:0]         rt_q, rt_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic [7:0]            llc_q, llc_d;
    logic                  areset_q, ready_q, fault_q;

    sync_2ff #(.W(NUM_PLLS)) u_sync (
        .clk (clk_100m_in),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lk_sync)
    );

    assign all_lk = &lk_sync;
    assign lose   = (state_q == S_RELEASE || state_q == S_RUN) && !all_lk;
    assign step   = state_q == S_RELEASE && all_lk && gap_q == GW'(STAGE_GAP - 1);

    always_comb begin
        state_d = state_q;
        rt_d    = rt_q;
        stage_d = stage_q;
        case (state_q)
            S_PLL_RESET: if (ar_q == AW'(ARESET_CYCLES - 1)) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK:
                if (all_lk) state_d = S_STABLE;
                else if (to_q == TW'(LOCK_TIMEOUT - 1)) begin
                    rt_d    = rt_q + 1'b1;
                    state_d = (rt_q == RW'(MAX_RETRIES - 1)) ? S_FAULT : S_PLL_RESET;
                end
            S_STABLE:
                if (!all_lk) state_d = S_WAIT_LOCK;
                else if (st_q == SW'(STABLE_CYCLES - 1)) begin
                    stage_d = NUM_STAGES'(1);
                    state_d = (NUM_STAGES == 1) ? S_RUN : S_RELEASE;
                end
            S_RELEASE:
                if (step) begin
                    stage_d = (stage_q << 1) | NUM_STAGES'(1);
                    if (&stage_d) state_d = S_RUN;
                end
            S_FAULT:
                if (retry_req) begin
                    state_d = S_PLL_RESET;
                    rt_d    = '0;
                end
            default: ;
        endcase
        // Lock loss overrides any same-cycle release
        if (lose) begin
            state_d = S_PLL_RESET;
            stage_d = '0;
        end
        if (state_d == S_RUN && state_q != S_RUN) rt_d = '0;
        llc_d = (lose && llc_q != 8'hFF) ? llc_q + 8'd1 : llc_q;
        ar_d  = (state_q == S_PLL_RESET && state_d == S_PLL_RESET) ? ar_q + 1'b1 : '0;
        to_d  = (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK) ? to_q + 1'b1 : '0;
        st_d  = (state_q == S_STABLE && state_d == S_STABLE) ? st_q + 1'b1 : '0;
        gap_d = (state_q == S_RELEASE && state_d == S_RELEASE && !step) ? gap_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_100m_in or posedge rst) begin
        if (rst) begin
            state_q  <= S_PLL_RESET;
            ar_q     <= '0;
            to_q     <= '0;
            st_q     <= '0;
            gap_q    <= '0;
            rt_q     <= '0;
            stage_q  <= '0;
            llc_q    <= '0;
            areset_q <= 1'b1;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            to_q     <= to_d;
            st_q     <= st_d;
            gap_q    <= gap_d;
            rt_q     <= rt_d;
            stage_q  <= stage_d;
            llc_q    <= llc_d;
            areset_q <= state_d == S_PLL_RESET || state_d == S_FAULT;
            ready_q  <= state_d == S_RUN;
            fault_q  <= state_d == S_FAULT;
        end
    end

    assign pll_areset      = areset_q;
    assign rst_stage_n     = stage_q;
    assign all_ready       = ready_q;
    assign fault           = fault_q;
    assign sup_state       = state_q;
    assign lock_loss_count = llc_q;
endmodule
